// File: rtl/ray_job_setup.sv
//------------------------------------------------------------------------------
// Module   : ray_job_setup
// Purpose  : Per-pixel DDA job generator. Accepts one screen pixel, forms a
//            pinhole-camera ray direction (dx, dy, DZ), and computes the per-axis
//            DDA increments floor(2^RECIP_LOG2/|d|) with one shared restoring
//            divider (one quotient bit per cycle, X then Y then Z). The
//            finished ray job is then presented on a valid/ready handshake.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            pix_valid/pix_ready - pixel request handshake (ready only in IDLE)
//            pix_x, pix_y        - pixel column/row, sampled at accept
//            job_valid/job_ready - job handshake (valid only in OUT)
//            job_ix0/iy0/iz0     - start voxel (camera position constants)
//            job_sx/sy/sz        - step signs (1 = non-negative direction)
//            job_next_*/job_inc_* - first crossing time and per-step increment
//            job_max_steps       - step limit constant
//            busy                - block is not idle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ray_job_setup #(
  parameter int SCREEN_CX      = 320,
  parameter int SCREEN_CY      = 240,
  parameter int DZ             = 128,
  parameter int RECIP_LOG2     = 24,
  parameter int COORD_W        = 6,
  parameter int TIMER_WIDTH    = 32,
  parameter int MAX_STEPS_BITS = 10,
  parameter int CAM_IX         = 16,
  parameter int CAM_IY         = 16,
  parameter int CAM_IZ         = 0,
  parameter int MAX_STEPS      = 200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  output logic                      job_valid,
  input  logic                      job_ready,
  output logic [COORD_W-1:0]        job_ix0,
  output logic [COORD_W-1:0]        job_iy0,
  output logic [COORD_W-1:0]        job_iz0,
  output logic                      job_sx,
  output logic                      job_sy,
  output logic                      job_sz,
  output logic [TIMER_WIDTH-1:0]    job_next_x,
  output logic [TIMER_WIDTH-1:0]    job_next_y,
  output logic [TIMER_WIDTH-1:0]    job_next_z,
  output logic [TIMER_WIDTH-1:0]    job_inc_x,
  output logic [TIMER_WIDTH-1:0]    job_inc_y,
  output logic [TIMER_WIDTH-1:0]    job_inc_z,
  output logic [MAX_STEPS_BITS-1:0] job_max_steps,
  output logic                      busy
);

  localparam int         QBITS    = RECIP_LOG2 + 1;
  localparam logic [4:0] LAST_BIT = 5'(QBITS - 1);
  localparam logic [10:0] MAG_Z   = 11'(DZ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV_X = 3'd1,
    S_DIV_Y = 3'd2,
    S_DIV_Z = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                   sx_q, sy_q, sz_q;
  logic [10:0]            mag_x_q, mag_y_q;
  logic [10:0]            rem_q, rem_d;
  logic [QBITS-2:0]       quo_q, quo_d;
  logic [4:0]             bit_cnt_q;
  logic [TIMER_WIDTH-1:0] inc_x_q, inc_y_q, inc_z_q;
  logic [TIMER_WIDTH-1:0] next_x_q, next_y_q, next_z_q;

  logic                   accept_w;
  logic                   in_div_w;
  logic                   div_last_w;
  logic [11:0]            dx_w, dy_w;
  logic [10:0]            divisor_w;
  logic [11:0]            trial_w, diff_w;
  logic                   ge_w;
  logic [QBITS-1:0]       quo_full_w;
  logic [TIMER_WIDTH-1:0] inc_w;

  assign accept_w   = pix_valid && (state_q == S_IDLE);
  assign in_div_w   = (state_q == S_DIV_X) || (state_q == S_DIV_Y) || (state_q == S_DIV_Z);
  assign div_last_w = in_div_w && (bit_cnt_q == LAST_BIT);

  // Two's-complement 12-bit directions; magnitudes always fit in 11 bits.
  assign dx_w = {2'b00, pix_x} - 12'(SCREEN_CX);
  assign dy_w = 12'(SCREEN_CY) - {2'b00, pix_y};

  always_comb begin
    divisor_w = mag_x_q;
    case (state_q)
      S_DIV_Y: divisor_w = mag_y_q;
      S_DIV_Z: divisor_w = MAG_Z;
      default: divisor_w = mag_x_q;
    endcase
  end

  // Dividend 2^RECIP_LOG2 has only its MSB set, so the bit shifted in is 1
  // on the first step and 0 afterwards.
  assign trial_w    = {rem_q, (bit_cnt_q == 5'd0)};
  assign diff_w     = trial_w - {1'b0, divisor_w};
  assign ge_w       = (trial_w >= {1'b0, divisor_w});
  assign rem_d      = 11'(ge_w ? diff_w : trial_w);
  assign quo_d      = {quo_q[QBITS-3:0], ge_w};
  assign quo_full_w = {quo_q, ge_w};
  // Division by zero saturates; the full bit count is still spent.
  assign inc_w      = (divisor_w == 11'd0) ? {TIMER_WIDTH{1'b1}} : TIMER_WIDTH'(quo_full_w);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pix_valid)  state_d = S_DIV_X;
      S_DIV_X: if (div_last_w) state_d = S_DIV_Y;
      S_DIV_Y: if (div_last_w) state_d = S_DIV_Z;
      S_DIV_Z: if (div_last_w) state_d = S_OUT;
      S_OUT:   if (job_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      sz_q      <= 1'b0;
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      bit_cnt_q <= '0;
      inc_x_q   <= '0;
      inc_y_q   <= '0;
      inc_z_q   <= '0;
      next_x_q  <= '0;
      next_y_q  <= '0;
      next_z_q  <= '0;
    end else if (accept_w) begin
      sx_q      <= ~dx_w[11];
      sy_q      <= ~dy_w[11];
      sz_q      <= 1'b1;
      mag_x_q   <= dx_w[11] ? (~dx_w[10:0] + 11'd1) : dx_w[10:0];
      mag_y_q   <= dy_w[11] ? (~dy_w[10:0] + 11'd1) : dy_w[10:0];
      rem_q     <= '0;
      quo_q     <= '0;
      bit_cnt_q <= '0;
    end else if (in_div_w) begin
      if (div_last_w) begin
        rem_q     <= '0;
        quo_q     <= '0;
        bit_cnt_q <= '0;
        case (state_q)
          S_DIV_X: begin inc_x_q <= inc_w; next_x_q <= inc_w >> 1; end
          S_DIV_Y: begin inc_y_q <= inc_w; next_y_q <= inc_w >> 1; end
          default: begin inc_z_q <= inc_w; next_z_q <= inc_w >> 1; end
        endcase
      end else begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
    end
  end

  assign pix_ready     = (state_q == S_IDLE);
  assign job_valid     = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign job_ix0       = COORD_W'(CAM_IX);
  assign job_iy0       = COORD_W'(CAM_IY);
  assign job_iz0       = COORD_W'(CAM_IZ);
  assign job_max_steps = MAX_STEPS_BITS'(MAX_STEPS);
  assign job_sx        = sx_q;
  assign job_sy        = sy_q;
  assign job_sz        = sz_q;
  assign job_inc_x     = inc_x_q;
  assign job_inc_y     = inc_y_q;
  assign job_inc_z     = inc_z_q;
  assign job_next_x    = next_x_q;
  assign job_next_y    = next_y_q;
  assign job_next_z    = next_z_q;

endmodule

`default_nettype wire

// File: tb/tb_ray_job_setup.sv
//------------------------------------------------------------------------------
// Module   : tb_ray_job_setup
// Purpose  : Self-checking bench for ray_job_setup. Directed pixels with
//            hand-computed increments are pushed to a scoreboard queue; a
//            monitor pops and compares when job_valid rises, and checks field
//            stability while the job is held.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ray_job_setup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        job_valid;
  logic        job_ready = 1'b1;
  logic [5:0]  job_ix0, job_iy0, job_iz0;
  logic        job_sx, job_sy, job_sz;
  logic [31:0] job_next_x, job_next_y, job_next_z;
  logic [31:0] job_inc_x, job_inc_y, job_inc_z;
  logic [9:0]  job_max_steps;
  logic        busy;

  ray_job_setup dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ix0(job_ix0), .job_iy0(job_iy0), .job_iz0(job_iz0),
    .job_sx(job_sx), .job_sy(job_sy), .job_sz(job_sz),
    .job_next_x(job_next_x), .job_next_y(job_next_y), .job_next_z(job_next_z),
    .job_inc_x(job_inc_x), .job_inc_y(job_inc_y), .job_inc_z(job_inc_z),
    .job_max_steps(job_max_steps), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sx, sy, sz;
    logic [31:0] ix, nx, iy, ny, iz, nz;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   jobs_done = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rst_n && job_valid && job_ready) jobs_done++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic sx, sy, input logic [31:0] ix, iy);
    exp_t e;
    e.sx = sx; e.sy = sy; e.sz = 1'b1;
    e.ix = ix; e.nx = ix >> 1;
    e.iy = iy; e.ny = iy >> 1;
    e.iz = 32'd131072; e.nz = 32'd65536;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [255:0] pack_fields();
    return {job_sx, job_sy, job_sz, job_inc_x, job_next_x, job_inc_y, job_next_y,
            job_inc_z, job_next_z};
  endfunction

  // Monitor: compare on the rising edge of job_valid, then hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (job_valid && !prev_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_job", 256'd1, 256'd0);
        end else begin
          cur = q.pop_front();
          chk("latency", 256'(cyc - cur.acc), 256'd75);
          chk("sx", 256'(job_sx), 256'(cur.sx));
          chk("sy", 256'(job_sy), 256'(cur.sy));
          chk("sz", 256'(job_sz), 256'(cur.sz));
          chk("inc_x", 256'(job_inc_x), 256'(cur.ix));
          chk("next_x", 256'(job_next_x), 256'(cur.nx));
          chk("inc_y", 256'(job_inc_y), 256'(cur.iy));
          chk("next_y", 256'(job_next_y), 256'(cur.ny));
          chk("inc_z", 256'(job_inc_z), 256'(cur.iz));
          chk("next_z", 256'(job_next_z), 256'(cur.nz));
          chk("const_fields", 256'({job_ix0, job_iy0, job_iz0, job_max_steps}),
              256'({6'd16, 6'd16, 6'd0, 10'd200}));
        end
      end else if (job_valid) begin
        chk("stable", pack_fields(),
            {cur.sx, cur.sy, cur.sz, cur.ix, cur.nx, cur.iy, cur.ny, cur.iz, cur.nz});
      end
      prev_valid = job_valid;
    end
  end

  task automatic send(input logic [9:0] x, input logic [9:0] y, input bit push, input exp_t e);
    int t;
    exp_t ee;
    t = 0;
    @(negedge clk);
    while (!pix_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!pix_ready) chk("accept_timeout", 256'd1, 256'd0);
    pix_x = x; pix_y = y; pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    ee = e;
    ee.acc = cyc;
    if (push) q.push_back(ee);
    // Later input changes must not affect the job.
    pix_x = 10'($urandom); pix_y = 10'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (busy || q.size() != 0) chk("idle_timeout", 256'd1, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int j0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pix_ready", 256'(pix_ready), 256'd1);
    chk("rst_job_valid", 256'(job_valid), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_fields", pack_fields(), 256'd0);
    chk("rst_const", 256'({job_ix0, job_iy0, job_iz0, job_max_steps}),
        256'({6'd16, 6'd16, 6'd0, 10'd200}));

    send(10'd320, 10'd240, 1'b1, mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF));
    wait_idle();
    send(10'd0, 10'd0, 1'b1, mk(1'b0, 1'b1, 32'd52428, 32'd69905));
    wait_idle();
    send(10'd639, 10'd479, 1'b1, mk(1'b1, 1'b0, 32'd52593, 32'd70197));
    wait_idle();
    send(10'd1023, 10'd1023, 1'b1, mk(1'b1, 1'b0, 32'd23865, 32'd21426));
    wait_idle();

    // Hold the job in OUT with job_ready low while pix inputs toggle.
    job_ready = 1'b0;
    send(10'd100, 10'd50, 1'b1, mk(1'b0, 1'b1, 32'd76260, 32'd88301));
    t = 0;
    while (!job_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hold_valid_seen", 256'(job_valid), 256'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_valid = 1'($urandom);
      pix_x = 10'($urandom);
      chk("hold_pix_ready", 256'(pix_ready), 256'd0);
      chk("hold_job_valid", 256'(job_valid), 256'd1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    j0 = jobs_done;
    job_ready = 1'b1;
    @(posedge clk);
    #1;
    job_ready = 1'b0;
    @(negedge clk);
    chk("pulse_job_valid", 256'(job_valid), 256'd0);
    chk("pulse_pix_ready", 256'(pix_ready), 256'd1);
    chk("pulse_one_job", 256'(jobs_done - j0), 256'd1);
    repeat (10) @(negedge clk);
    chk("no_queued_pixel", 256'(busy), 256'd0);
    job_ready = 1'b1;

    // Reset 30 cycles into a job: nothing is emitted, state clears at once.
    send(10'd500, 10'd100, 1'b0, mk(1'b1, 1'b1, 32'd0, 32'd0));
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_job_valid", 256'(job_valid), 256'd0);
    chk("midrst_busy", 256'(busy), 256'd0);
    chk("midrst_pix_ready", 256'(pix_ready), 256'd1);
    chk("midrst_inc_x", 256'(job_inc_x), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(10'd330, 10'd250, 1'b1, mk(1'b1, 1'b0, 32'd1677721, 32'd1677721));
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", 256'(q.size()), 256'd0);
    chk("job_count", 256'(jobs_done), 256'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
